// File: rtl/dppm_frame_encoder_pkg.sv
// rtl/dppm_frame_encoder_pkg.sv - shared FSM states, LED levels and LED decode for the D-PPM encoder
package dppm_frame_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_START = 3'd2,
    ST_GAP   = 3'd3,
    ST_PULSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;

  // LED level a state drives; in the preamble only the pulse half of each pair lights the LED
  function automatic logic led_level(input state_t s, input logic pre_low);
    if (s == ST_START || s == ST_PULSE || (s == ST_PRE && !pre_low)) begin
      return LED_ON;
    end
    return LED_OFF;
  endfunction

endpackage

// File: rtl/dppm_interval_timer.sv
// rtl/dppm_interval_timer.sv - up-counting interval timer with load, end-of-interval strobe and pause
module dppm_interval_timer #(
  parameter int COUNTER_SIZE = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] target,
  output logic                    done
);

  logic [COUNTER_SIZE-1:0] count;

  // Restart at zero on load, otherwise advance one per enabled cycle and hold while paused
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Strobe in the last cycle of a target-cycle interval; never while paused
  assign done = enable && (count == target - 1'b1);

endmodule

// File: rtl/dppm_frame_encoder.sv
// rtl/dppm_frame_encoder.sv - D-PPM frame transmitter; optional preamble under LIGHTIO_PREAMBLE_EN
module dppm_frame_encoder
  import dppm_frame_encoder_pkg::*;
#(
  parameter int FRAME_SIZE    = 32,
  parameter int SYM_BITS      = 1,
  parameter int COUNTER_SIZE  = 8,
  parameter int INTERVAL_BASE = 4,
  parameter int INTERVAL_STEP = 4,
  parameter int PULSE_WIDTH   = 1,
  parameter int PREAMBLE_LEN  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [FRAME_SIZE-1:0] frame_data,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  led,
  output logic                  busy,
  output logic                  irq
);

  localparam int NUM_SYMS     = FRAME_SIZE / SYM_BITS;
  localparam int SYM_CNT_W    = $clog2(NUM_SYMS + 1);
  localparam int MAX_INTERVAL = INTERVAL_BASE + (2 ** SYM_BITS - 1) * INTERVAL_STEP + PULSE_WIDTH;

  // Elaboration-time guard: counter must not wrap and the frame must split into whole symbols
  if (MAX_INTERVAL >= 2 ** COUNTER_SIZE || FRAME_SIZE % SYM_BITS != 0 || SYM_BITS < 1 || SYM_BITS > 4 ||
      INTERVAL_BASE < 1 || INTERVAL_STEP < 1 || PULSE_WIDTH < 1) begin : g_bad_config
    $error("dppm_frame_encoder: illegal parameter set");
  end

  state_t                  state, next_state;
  logic [FRAME_SIZE-1:0]   shreg;
  logic [SYM_CNT_W-1:0]    sym_cnt;
  logic                    led_q;
  logic                    accept;
  logic                    active;
  logic                    last_sym;
  logic                    tmr_done;
  logic                    tmr_load;
  logic [COUNTER_SIZE-1:0] tmr_target;
  logic [COUNTER_SIZE-1:0] gap_target;
  logic                    pre_low_d;

`ifdef LIGHTIO_PREAMBLE_EN
  localparam int PRE_CNT_W = $clog2(PREAMBLE_LEN + 1);
  logic                 pre_low;
  logic [PRE_CNT_W-1:0] pre_cnt, pre_cnt_d;
`endif

  assign active      = (state != ST_IDLE) && (state != ST_DONE);
  assign frame_ready = enable && !reset && !active;
  assign accept      = frame_valid && frame_ready;
  assign busy        = active;
  assign led         = led_q && enable;
  assign last_sym    = (sym_cnt == SYM_CNT_W'(1));
  assign gap_target  = COUNTER_SIZE'(INTERVAL_BASE) +
                       COUNTER_SIZE'(shreg[SYM_BITS-1:0]) * COUNTER_SIZE'(INTERVAL_STEP);
  // Every finished interval (and any idle cycle) restarts the timer for the next one
  assign tmr_load    = tmr_done || !active;

  dppm_interval_timer #(
    .COUNTER_SIZE(COUNTER_SIZE)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .load  (tmr_load),
    .target(tmr_target),
    .done  (tmr_done)
  );

  // Next state, interval target and preamble sub-phase; a paused timer never strobes so the FSM freezes
  always_comb begin
    next_state = state;
    tmr_target = COUNTER_SIZE'(PULSE_WIDTH);
    pre_low_d  = 1'b0;
`ifdef LIGHTIO_PREAMBLE_EN
    pre_low_d  = pre_low;
    pre_cnt_d  = pre_cnt;
`endif
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef LIGHTIO_PREAMBLE_EN
          next_state = ST_PRE;
          pre_low_d  = 1'b0;
          pre_cnt_d  = '0;
`else
          next_state = ST_START;
`endif
        end
      end
`ifdef LIGHTIO_PREAMBLE_EN
      ST_PRE: begin
        tmr_target = pre_low ? COUNTER_SIZE'(INTERVAL_BASE) : COUNTER_SIZE'(PULSE_WIDTH);
        if (tmr_done) begin
          if (!pre_low) begin
            pre_low_d = 1'b1;
          end else begin
            pre_low_d = 1'b0;
            pre_cnt_d = pre_cnt + 1'b1;
            if (pre_cnt == PRE_CNT_W'(PREAMBLE_LEN - 1)) begin
              next_state = ST_START;
            end
          end
        end
      end
`endif
      ST_START: begin
        if (tmr_done) next_state = ST_GAP;
      end
      ST_GAP: begin
        tmr_target = gap_target;
        if (tmr_done) next_state = ST_PULSE;
      end
      ST_PULSE: begin
        if (tmr_done) next_state = last_sym ? ST_DONE : ST_GAP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, registered LED, symbol shift register/count and sticky done flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      led_q   <= LED_OFF;
      shreg   <= '0;
      sym_cnt <= '0;
      irq     <= 1'b0;
    end else begin
      state <= next_state;
      led_q <= led_level(next_state, pre_low_d);
      if (accept) begin
        shreg   <= frame_data;
        sym_cnt <= SYM_CNT_W'(NUM_SYMS);
        irq     <= 1'b0;
      end else if (state == ST_PULSE && tmr_done) begin
        shreg   <= shreg >> SYM_BITS;
        sym_cnt <= sym_cnt - 1'b1;
        if (last_sym) irq <= 1'b1;
      end
    end
  end

`ifdef LIGHTIO_PREAMBLE_EN
  // Preamble pulse/low sub-phase and pulse count
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_low <= 1'b0;
      pre_cnt <= '0;
    end else begin
      pre_low <= pre_low_d;
      pre_cnt <= pre_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dppm_frame_encoder.sv
// tb/tb_dppm_frame_encoder.sv - directed self-checking bench for dppm_frame_encoder
module tb_dppm_frame_encoder;

  localparam int PLEN = 4;
`ifdef LIGHTIO_PREAMBLE_EN
  localparam int OFF = PLEN * (1 + 4);
`else
  localparam int OFF = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] frame_data;
  logic       valid1, ready1, led1, busy1, irq1;
  logic       valid2, ready2, led2, busy2, irq2;

  int checks = 0;
  int fails  = 0;

  logic [127:0] led_tr, irq_tr, busy_tr;
  logic [127:0] exp_led, exp_irq, exp_busy;

  always #5 clock = ~clock;

  dppm_frame_encoder #(
    .FRAME_SIZE(8), .SYM_BITS(1), .COUNTER_SIZE(8), .INTERVAL_BASE(4),
    .INTERVAL_STEP(4), .PULSE_WIDTH(1), .PREAMBLE_LEN(PLEN)
  ) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .frame_data(frame_data),
    .frame_valid(valid1), .frame_ready(ready1), .led(led1), .busy(busy1), .irq(irq1)
  );

  dppm_frame_encoder #(
    .FRAME_SIZE(8), .SYM_BITS(2), .COUNTER_SIZE(8), .INTERVAL_BASE(4),
    .INTERVAL_STEP(4), .PULSE_WIDTH(1), .PREAMBLE_LEN(PLEN)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .frame_data(frame_data),
    .frame_valid(valid2), .frame_ready(ready2), .led(led2), .busy(busy2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record led/irq/busy for cycles 1..n after an accept; enable is low for cycles p_lo..p_hi
  task automatic capture(input int which, input int n, input int p_lo, input int p_hi);
    led_tr = '0; irq_tr = '0; busy_tr = '0;
    for (int c = 1; c <= n; c++) begin
      enable = !(c >= p_lo && c <= p_hi);
      @(negedge clock);
      led_tr[c]  = (which == 1) ? led1  : led2;
      irq_tr[c]  = (which == 1) ? irq1  : irq2;
      busy_tr[c] = (which == 1) ? busy1 : busy2;
      @(posedge clock); #1;
    end
    enable = 1'b1;
  endtask

  task automatic clear_exp();
    exp_led = '0; exp_irq = '0; exp_busy = '0;
`ifdef LIGHTIO_PREAMBLE_EN
    for (int k = 0; k < PLEN; k++) exp_led[1 + 5 * k] = 1'b1;
`endif
  endtask

  task automatic set_range(inout logic [127:0] v, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) v[c] = 1'b1;
  endtask

  // Present one frame and clock it in; returns one cycle after the accept edge
  task automatic accept(input int which, input logic [7:0] data);
    frame_data = data;
    if (which == 1) valid1 = 1'b1; else valid2 = 1'b1;
    check("ready_before_accept", (which == 1) ? ready1 : ready2, 1'b1);
    @(posedge clock); #1;
    valid1 = 1'b0; valid2 = 1'b0;
  endtask

  int p_a5[9]    = '{1, 10, 15, 24, 29, 34, 43, 48, 57};
  int p_pause[9] = '{1, 20, 25, 34, 39, 44, 53, 58, 67};
  int p_e4[5]    = '{1, 6, 15, 28, 45};

  initial begin
    reset = 1'b1; enable = 1'b1; frame_data = '0; valid1 = 1'b0; valid2 = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", ready1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_led", led1, 1'b0);
    check("reset_busy", busy1, 1'b0);
    check("reset_irq", irq1, 1'b0);
    check("ready_idle1", ready1, 1'b1);
    check("ready_idle2", ready2, 1'b1);
    @(posedge clock); #1;

    // Binary frame 8'hA5: gaps 8,4,8,4,4,8,4,8
    accept(1, 8'hA5);
    capture(1, 60 + OFF, 0, -1);
    clear_exp();
    for (int i = 0; i < 9; i++) exp_led[p_a5[i] + OFF] = 1'b1;
    set_range(exp_irq, 58 + OFF, 60 + OFF);
    set_range(exp_busy, 1, 57 + OFF);
    check("a5_led", led_tr, exp_led);
    check("a5_irq", irq_tr, exp_irq);
    check("a5_busy", busy_tr, exp_busy);

    // Accept straight out of DONE with valid held high through the whole frame
    frame_data = 8'h00;
    valid1 = 1'b1;
    check("ready_in_done", ready1, 1'b1);
    @(posedge clock); #1;
    capture(1, 43 + OFF, 0, -1);
    valid1 = 1'b0;
    clear_exp();
    for (int k = 0; k < 9; k++) exp_led[1 + 5 * k + OFF] = 1'b1;
    exp_led[43 + OFF] = 1'b1;
    exp_irq[42 + OFF] = 1'b1;
    set_range(exp_busy, 1, 41 + OFF);
    exp_busy[43 + OFF] = 1'b1;
    check("held_valid_led", led_tr, exp_led);
    check("held_valid_irq", irq_tr, exp_irq);
    check("held_valid_busy", busy_tr, exp_busy);

    // Frame of zeros just accepted; frame_data changes must not matter. Trace index i is frame cycle i+1.
    frame_data = 8'hFF;
    capture(1, 18, 0, -1);
    exp_led = '0;
    exp_led[5] = 1'b1; exp_led[10] = 1'b1; exp_led[15] = 1'b1;
    check("pre_reset_led", led_tr, exp_led);

    // Reset in frame cycle 20 aborts the frame
    reset = 1'b1;
    @(negedge clock);
    check("ready_in_midreset", ready1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_led", led1, 1'b0);
    check("abort_busy", busy1, 1'b0);
    check("abort_irq", irq1, 1'b0);
    @(posedge clock); #1;

    // Clean restart of 8'hA5 with a 10-cycle pause inside the first gap
    accept(1, 8'hA5);
    capture(1, 70 + OFF, 4 + OFF, 13 + OFF);
    clear_exp();
    for (int i = 0; i < 9; i++) exp_led[p_pause[i] + OFF] = 1'b1;
    set_range(exp_irq, 68 + OFF, 70 + OFF);
    set_range(exp_busy, 1, 67 + OFF);
    check("pause_led", led_tr, exp_led);
    check("pause_irq", irq_tr, exp_irq);
    check("pause_busy", busy_tr, exp_busy);

    // 4-ary frame 8'hE4: symbols 0,1,2,3 -> gaps 4,8,12,16
    accept(2, 8'hE4);
    capture(2, 48 + OFF, 0, -1);
    clear_exp();
    for (int i = 0; i < 5; i++) exp_led[p_e4[i] + OFF] = 1'b1;
    set_range(exp_irq, 46 + OFF, 48 + OFF);
    set_range(exp_busy, 1, 45 + OFF);
    check("e4_led", led_tr, exp_led);
    check("e4_irq", irq_tr, exp_irq);
    check("e4_busy", busy_tr, exp_busy);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
